instruction_queue: RTL and testbench

- In-order tracking queue for issued instructions awaiting write-back. It is the producer end of the write-back queue interface.
- Issue pushes one entry per cycle: unit_id, instruction id, rd_addr. Write-back pops any entry by position, out of order.
- Slot 0 holds the youngest entry; higher indices hold older entries. Entries shift up one slot per cycle to close holes.
- Per-slot valid, shift and data outputs let write-back find the oldest entry and correct its registered pop index.

---
 rtl/instruction_queue_if.sv | 29 ++
 rtl/instruction_queue.sv | 93 +++++++++
 tb/tb_instruction_queue.sv | 212 +++++++++++++++++++++
 3 files changed

// File: rtl/instruction_queue_if.sv
// rtl/instruction_queue_if.sv - issue/write-back handshake bundle for instruction_queue
interface instruction_queue_if #(
    parameter int DEPTH  = 4,
    parameter int UNIT_W = 3,
    parameter int ID_W   = 3
);
    logic                    push;
    logic [UNIT_W-1:0]       push_unit_id;
    logic [ID_W-1:0]         push_id;
    logic [4:0]              push_rd_addr;
    logic                    full;
    logic                    empty;
    logic [DEPTH-1:0]        pop;
    logic [DEPTH-1:0]        valid;
    logic [DEPTH-1:0]        shift_pop;
    logic [DEPTH*UNIT_W-1:0] unit_id_out;
    logic [DEPTH*ID_W-1:0]   id_out;
    logic [DEPTH*5-1:0]      rd_addr_out;

    modport master (
        output push, push_unit_id, push_id, push_rd_addr, pop,
        input  full, empty, valid, shift_pop, unit_id_out, id_out, rd_addr_out
    );

    modport slave (
        input  push, push_unit_id, push_id, push_rd_addr, pop,
        output full, empty, valid, shift_pop, unit_id_out, id_out, rd_addr_out
    );
endinterface

// File: rtl/instruction_queue.sv
// rtl/instruction_queue.sv - in-order issue tracking queue, out-of-order pop, hole-closing shift (INSTRUCTION_QUEUE_FLUSH_EN adds flush)
module instruction_queue #(
    parameter int DEPTH  = 4,
    parameter int UNIT_W = 3,
    parameter int ID_W   = 3
) (
    input  logic clk,
    input  logic rst,
`ifdef INSTRUCTION_QUEUE_FLUSH_EN
    input  logic flush,
`endif
    instruction_queue_if.slave q
);
    logic [DEPTH-1:0]  valid_r;
    logic [UNIT_W-1:0] unit_r [DEPTH];
    logic [ID_W-1:0]   id_r   [DEPTH];
    logic [4:0]        rd_r   [DEPTH];

    logic [DEPTH-1:0]  live;
    logic [DEPTH-1:0]  shift;
    logic              full_c;
    logic              accept;
    logic              clear;

`ifdef INSTRUCTION_QUEUE_FLUSH_EN
    assign clear = rst | flush;
`else
    assign clear = rst;
`endif

    // Shift chain resolves from the oldest slot down so a hole pulls the whole run below it.
    always_comb begin
        live             = valid_r & ~q.pop;
        shift            = '0;
        shift[DEPTH-1]   = 1'b0;
        for (int i = DEPTH - 2; i >= 0; i--) begin
            shift[i] = valid_r[i] & (~live[i+1] | shift[i+1]);
        end
`ifdef INSTRUCTION_QUEUE_FLUSH_EN
        full_c = ~(~valid_r[0] | q.pop[0] | shift[0]) | flush;
`else
        full_c = ~(~valid_r[0] | q.pop[0] | shift[0]);
`endif
        accept = q.push & ~full_c;
    end

    always_ff @(posedge clk) begin
        if (clear) begin
            valid_r <= '0;
        end else begin
            if (accept)        valid_r[0] <= 1'b1;
            else if (shift[0]) valid_r[0] <= 1'b0;
            else               valid_r[0] <= live[0];
            for (int i = 1; i < DEPTH; i++) begin
                if (shift[i-1])  valid_r[i] <= live[i-1];
                else if (shift[i]) valid_r[i] <= 1'b0;
                else             valid_r[i] <= live[i];
            end
        end
    end

    // Payload needs no reset: valid_r masks stale contents.
    always_ff @(posedge clk) begin
        if (accept) begin
            unit_r[0] <= q.push_unit_id;
            id_r[0]   <= q.push_id;
            rd_r[0]   <= q.push_rd_addr;
        end
        for (int i = 1; i < DEPTH; i++) begin
            if (shift[i-1]) begin
                unit_r[i] <= unit_r[i-1];
                id_r[i]   <= id_r[i-1];
                rd_r[i]   <= rd_r[i-1];
            end
        end
    end

    always_comb begin
        q.unit_id_out = '0;
        q.id_out      = '0;
        q.rd_addr_out = '0;
        for (int i = 0; i < DEPTH; i++) begin
            q.unit_id_out[i*UNIT_W +: UNIT_W] = unit_r[i];
            q.id_out[i*ID_W +: ID_W]          = id_r[i];
            q.rd_addr_out[i*5 +: 5]           = rd_r[i];
        end
    end

    assign q.valid     = valid_r;
    assign q.shift_pop = shift;
    assign q.full      = full_c;
    assign q.empty     = ~|valid_r;
endmodule

// File: tb/tb_instruction_queue.sv
// tb/tb_instruction_queue.sv - directed self-checking bench for instruction_queue
module tb_instruction_queue;
    logic clk = 1'b0;
    logic rst = 1'b1;
`ifdef INSTRUCTION_QUEUE_FLUSH_EN
    logic flush = 1'b0;
`endif
    int tests = 0;
    int fails = 0;

    instruction_queue_if #(.DEPTH(4), .UNIT_W(3), .ID_W(3)) bus ();

    instruction_queue #(.DEPTH(4), .UNIT_W(3), .ID_W(3)) dut (
        .clk  (clk),
        .rst  (rst),
`ifdef INSTRUCTION_QUEUE_FLUSH_EN
        .flush(flush),
`endif
        .q    (bus.slave)
    );

    always #5 clk = ~clk;

    logic [11:0] id_bus;
    logic [11:0] unit_bus;
    logic [19:0] rd_bus;
    assign id_bus   = bus.id_out;
    assign unit_bus = bus.unit_id_out;
    assign rd_bus   = bus.rd_addr_out;

    function automatic logic [31:0] sid(int i);
        return {29'd0, id_bus[i*3 +: 3]};
    endfunction

    task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_push(logic en, int id);
        bus.push         = en;
        bus.push_id      = id[2:0];
        bus.push_unit_id = id[2:0];
        bus.push_rd_addr = 5'(id + 10);
    endtask

    initial begin
        bus.pop = '0;
        drive_push(1'b0, 0);
        tick();
        tick();
        rst = 1'b0;
        #1;
        check("reset_valid", {28'd0, bus.valid}, 32'h0);
        check("reset_empty", {31'd0, bus.empty}, 32'h1);
        check("reset_full", {31'd0, bus.full}, 32'h0);
        check("reset_shift", {28'd0, bus.shift_pop}, 32'h0);

        for (int k = 0; k < 4; k++) begin
            drive_push(1'b1, k);
            tick();
        end
        drive_push(1'b0, 0);
        #1;
        check("fill_valid", {28'd0, bus.valid}, 32'hF);
        check("fill_full", {31'd0, bus.full}, 32'h1);
        check("fill_empty", {31'd0, bus.empty}, 32'h0);
        check("fill_slot3_id", sid(3), 32'd0);
        check("fill_slot0_id", sid(0), 32'd3);
        check("fill_slot3_rd", {27'd0, rd_bus[19:15]}, 32'd10);
        check("fill_slot0_unit", {29'd0, unit_bus[2:0]}, 32'd3);

        drive_push(1'b1, 5);
        #1;
        check("drop_full", {31'd0, bus.full}, 32'h1);
        tick();
        drive_push(1'b0, 0);
        #1;
        check("drop_valid", {28'd0, bus.valid}, 32'hF);
        check("drop_slot0_id", sid(0), 32'd3);

        bus.pop = 4'b1000;
        #1;
        check("pop3_shift", {28'd0, bus.shift_pop}, 32'h7);
        check("pop3_full", {31'd0, bus.full}, 32'h0);
        tick();
        bus.pop = '0;
        #1;
        check("pop3_valid", {28'd0, bus.valid}, 32'hE);
        check("pop3_slot3_id", sid(3), 32'd1);
        check("pop3_slot1_id", sid(1), 32'd3);
        check("settled_shift", {28'd0, bus.shift_pop}, 32'h0);

        drive_push(1'b1, 4);
        tick();
        drive_push(1'b0, 0);
        #1;
        check("refill_valid", {28'd0, bus.valid}, 32'hF);
        check("refill_slot0_id", sid(0), 32'd4);

        bus.pop = 4'b1000;
        drive_push(1'b1, 5);
        tick();
        bus.pop = '0;
        drive_push(1'b0, 0);
        #1;
        check("pop3push_valid", {28'd0, bus.valid}, 32'hF);
        check("pop3push_slot3_id", sid(3), 32'd2);
        check("pop3push_slot0_id", sid(0), 32'd5);

        bus.pop = 4'b0010;
        #1;
        check("pop1_shift", {28'd0, bus.shift_pop}, 32'h1);
        tick();
        bus.pop = '0;
        #1;
        check("pop1_valid", {28'd0, bus.valid}, 32'hE);
        check("pop1_slot1_id", sid(1), 32'd5);
        check("pop1_slot2_id", sid(2), 32'd3);
        check("pop1_slot3_id", sid(3), 32'd2);

        drive_push(1'b1, 6);
        tick();
        drive_push(1'b0, 0);
        #1;
        check("push6_valid", {28'd0, bus.valid}, 32'hF);

        bus.pop = 4'b0101;
        drive_push(1'b1, 7);
        #1;
        check("pop02_shift", {28'd0, bus.shift_pop}, 32'h3);
        tick();
        bus.pop = '0;
        drive_push(1'b0, 0);
        #1;
        check("pop02_valid", {28'd0, bus.valid}, 32'hD);
        check("pop02_slot0_id", sid(0), 32'd7);
        check("pop02_slot2_id", sid(2), 32'd5);
        check("pop02_slot3_id", sid(3), 32'd2);

        rst = 1'b1;
        tick();
        rst = 1'b0;
        bus.pop = 4'b0100;
        drive_push(1'b1, 1);
        tick();
        bus.pop = '0;
        drive_push(1'b0, 0);
        #1;
        check("bogus_pop_valid", {28'd0, bus.valid}, 32'h1);
        check("bogus_pop_empty", {31'd0, bus.empty}, 32'h0);
        check("bogus_pop_slot0_id", sid(0), 32'd1);

        bus.pop = 4'b0001;
        drive_push(1'b1, 2);
        tick();
        bus.pop = '0;
        #1;
        check("pushpop0_valid", {28'd0, bus.valid}, 32'h1);
        check("pushpop0_slot0_id", sid(0), 32'd2);

        drive_push(1'b1, 3);
        tick();
        drive_push(1'b1, 4);
        tick();
        drive_push(1'b0, 0);
        #1;
        check("three_valid", {28'd0, bus.valid}, 32'h7);
        check("three_slot2_id", sid(2), 32'd2);

        rst = 1'b1;
        drive_push(1'b1, 5);
        tick();
        rst = 1'b0;
        drive_push(1'b0, 0);
        #1;
        check("midrst_valid", {28'd0, bus.valid}, 32'h0);
        check("midrst_empty", {31'd0, bus.empty}, 32'h1);
        check("midrst_full", {31'd0, bus.full}, 32'h0);

`ifdef INSTRUCTION_QUEUE_FLUSH_EN
        drive_push(1'b1, 1);
        tick();
        drive_push(1'b1, 2);
        tick();
        drive_push(1'b1, 3);
        tick();
        flush = 1'b1;
        drive_push(1'b1, 4);
        #1;
        check("flush_full", {31'd0, bus.full}, 32'h1);
        tick();
        flush = 1'b0;
        drive_push(1'b0, 0);
        #1;
        check("flush_valid", {28'd0, bus.valid}, 32'h0);
        check("flush_empty", {31'd0, bus.empty}, 32'h1);
        check("flush_full_after", {31'd0, bus.full}, 32'h0);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
